instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 6, width of program address.
REQ-002 Parameter DATA_W, default 16, width of instruction word.
REQ-003 Parameter DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 pc_addr  input  ADDR_W  address presented by program counter.
REQ-007 pc_valid  input  1  pc_addr is valid this cycle.
REQ-008 pc_stall  output  1  high = PC shall hold its address; address not accepted.
REQ-009 flush  input  1  discard all buffered and in-flight instructions (branch/redirect).
REQ-010 rom_en  output  1  synchronous ROM read enable.
REQ-011 rom_addr  output  ADDR_W  ROM read address.
REQ-012 rom_data  input  DATA_W  ROM read data, valid exactly one cycle after rom_en.
REQ-013 instr  output  DATA_W  instruction at buffer head.
REQ-014 instr_addr  output  ADDR_W  address of instruction at buffer head.
REQ-015 instr_valid  output  1  head entry valid.
REQ-016 instr_ready  input  1  decoder accepts head entry.

Function
REQ-017 Accept: address accepted in cycle N iff pc_valid=1, pc_stall=0, flush=0.
REQ-018 On accept, rom_en=1 and rom_addr=pc_addr combinationally in cycle N; otherwise rom_en=0, rom_addr=pc_addr.
REQ-019 In-flight flag set at end of accept cycle, together with captured address; cleared next cycle unless a new accept occurs.
REQ-020 Cycle N+1: rom_data and captured address written to buffer tail at end of cycle; instr_valid=1 no earlier than cycle N+2 (2-cycle accept-to-valid latency when empty).
REQ-021 Pop: head removed at end of cycle when instr_valid=1 and instr_ready=1; instr/instr_addr hold stable while instr_valid=1 and instr_ready=0.
REQ-022 Credit rule: pc_stall = flush OR (count + inflight >= DEPTH), from registered state only (no path from instr_ready).
REQ-023 Buffer never overflows; write with count=DEPTH is impossible by REQ-022 and is an assertion failure.
REQ-024 Simultaneous write and pop: count unchanged, both pointers advance.
REQ-025 Pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-026 Empty: instr_valid=0; instr/instr_addr are don't-care.
REQ-027 Flush in cycle F: count, pointers, in-flight flag cleared at end of F; rom_data returning in F+1 for a read issued before F is dropped; no accept in F.
REQ-028 Flush has priority over simultaneous write, pop and accept; pop handshake in cycle F has no effect on state.
REQ-029 Accepted addresses emerge on instr_addr in acceptance order, each exactly once unless flushed.

Reset
REQ-030 reset has priority over flush and all handshakes.
REQ-031 During/after reset: count=0, pointers=0, in-flight=0; instr_valid=0, rom_en=0, pc_stall=0 in the first cycle after reset deasserts.
REQ-032 Reset mid-operation discards buffered and in-flight data identically to flush; rom_data in the cycle after reset is ignored.
REQ-033 Buffer storage array is not reset.

Structure
REQ-034 Shared package fetch_pkg holds ADDR_W/DATA_W defaults and typedef fetch_entry_t {addr, data}.
REQ-035 Buffer implemented as one sub-module fetch_fifo (synchronous, DEPTH entries of fetch_entry_t, with clear input driven by flush or reset).
REQ-036 instr_fetch contains only accept logic, in-flight register, credit computation and fetch_fifo instance.

Verification
REQ-037 Reset then pc_valid=1 addr 0,1,2,... with instr_ready=1, ROM[i]=i+0x100 -> instr_valid first high 2 cycles after first accept, instr_addr 0,1,2,... one per cycle, instr=0x100,0x101,...
REQ-038 instr_ready=0, continuous pc_valid -> exactly 4 addresses (0..3) accepted, pc_stall=1 from cycle after 4th accept; instr_ready=1 for one cycle -> address 4 accepted next cycle.
REQ-039 Buffer holding addr 5,6 with read for 7 in flight, flush=1 -> instr_valid=0 next cycle, ROM data for 7 dropped; next accepted addr 20 -> instr_addr=20 appears, 7 never appears.
REQ-040 Count=DEPTH with simultaneous pop and no accept -> count=3, pc_stall=0 following cycle; pointer wrap exercised by 10 push/pop pairs, order preserved.
REQ-041 Reset asserted with 3 entries buffered -> instr_valid=0, pc_stall=0 after reset; next accept addr 0 -> instr_addr=0 after 2 cycles.
REQ-042 Randomized valid/ready with scoreboard over 1000 cycles -> no loss, duplication or reordering; overflow assertion never fires.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared widths and buffer entry type for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 6;
    localparam int unsigned FETCH_DATA_W = 16;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// PC, ROM and decoder-side signals of the fetch unit, bundled for port connection.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic              pc_stall;
    logic              flush;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              instr_ready;

    // Environment side: program counter, ROM and decoder.
    modport master (
        output pc_addr, pc_valid, flush, rom_data, instr_ready,
        input  pc_stall, rom_en, rom_addr, instr, instr_addr, instr_valid
    );

    // Fetch unit side.
    modport slave (
        input  pc_addr, pc_valid, flush, rom_data, instr_ready,
        output pc_stall, rom_en, rom_addr, instr, instr_addr, instr_valid
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of fetch entries with a
// synchronous clear. Storage is not reset; only pointers and count are.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             wr_en,
    input  fetch_entry_t     wr_data,
    input  logic             rd_en,
    output fetch_entry_t     rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;

    assign rd_valid = (count != '0);
    assign pop      = rd_en && rd_valid;
    assign rd_data  = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) mem[wr_ptr] <= wr_data;
    end

    // Credit flow control upstream must make a write into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk)
        !(wr_en && !clear && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: accepts PC addresses against buffer credit,
// reads a synchronous ROM and queues (addr, data) pairs for the decoder.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              accept;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic [DATA_W-1:0] rom_word;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;
    logic              fifo_clear;
    logic              head_valid;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;

    // Credit uses registered state only, so instr_ready never reaches pc_stall.
    assign credit_used  = {1'b0, count} + (CNT_W+1)'(inflight);
    assign bus.pc_stall = bus.flush || (credit_used >= (CNT_W+1)'(DEPTH));
    assign accept       = bus.pc_valid && !bus.pc_stall;

    assign bus.rom_en   = accept;
    assign bus.rom_addr = bus.pc_addr;

    // One ROM read is outstanding at most one cycle; its address rides alongside.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) inflight_addr <= bus.pc_addr;
        end
    end

    assign rom_word   = bus.rom_data;
    assign wr_entry   = '{addr: inflight_addr, data: rom_word};
    assign fifo_clear = reset || bus.flush;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .clear    (fifo_clear),
        .wr_en    (inflight),
        .wr_data  (wr_entry),
        .rd_en    (bus.instr_ready),
        .rd_data  (head),
        .rd_valid (head_valid),
        .count    (count)
    );

    assign bus.instr       = head.data;
    assign bus.instr_addr  = head.addr;
    assign bus.instr_valid = head_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized checks of instr_fetch with a scoreboard monitor.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t e;

    logic          prev_hold;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] next_addr;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return DW'(a) + DW'(16'h100);
    endfunction

    // Synchronous ROM model; junk when not enabled so stray writes show up.
    always @(posedge clk) begin
        bus.rom_data <= bus.rom_en ? rom_word(bus.rom_addr) : DW'(16'hdead);
    end

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Scoreboard monitor: record accepts, compare every popped head in order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(bus.instr_valid), 1);
                check("hold_addr", 32'(bus.instr_addr), 32'(prev_addr));
                check("hold_data", 32'(bus.instr), 32'(prev_data));
            end
            prev_hold = bus.instr_valid && !bus.instr_ready && !bus.flush;
            prev_addr = bus.instr_addr;
            prev_data = bus.instr;
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got addr 0x%0h expected none at %0t",
                             bus.instr_addr, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_addr", 32'(bus.instr_addr), 32'(e.addr));
                    check("sb_data", 32'(bus.instr), 32'(e.data));
                end
            end
            if (bus.flush) exp_q.delete();
            else if (bus.pc_valid && !bus.pc_stall)
                exp_q.push_back('{addr: bus.pc_addr, data: rom_word(bus.pc_addr)});
        end
    end

    // Drive one cycle of inputs just after the edge, then sit at the falling edge.
    task automatic cyc(input logic v, input logic [AW-1:0] a, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        bus.pc_valid    = v;
        bus.pc_addr     = a;
        bus.instr_ready = rdy;
        bus.flush       = fl;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset           = 1'b1;
        bus.pc_valid    = 1'b0;
        bus.pc_addr     = '0;
        bus.instr_ready = 1'b0;
        bus.flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        bus.pc_valid    = 1'b0;
        bus.pc_addr     = '0;
        bus.instr_ready = 1'b0;
        bus.flush       = 1'b0;

        // Reset state and streaming with 2-cycle latency
        do_reset();
        check("rst_valid", 32'(bus.instr_valid), 0);
        check("rst_rom_en", 32'(bus.rom_en), 0);
        check("rst_stall", 32'(bus.pc_stall), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, AW'(i), 1'b1, 1'b0);
            check("t1_rom_en", 32'(bus.rom_en), 1);
            check("t1_rom_addr", 32'(bus.rom_addr), i);
            if (i < 2) begin
                check("t1_latency", 32'(bus.instr_valid), 0);
            end else begin
                check("t1_valid", 32'(bus.instr_valid), 1);
                check("t1_addr", 32'(bus.instr_addr), i - 2);
                check("t1_data", 32'(bus.instr), 32'h100 + i - 2);
            end
        end
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_empty", 32'(bus.instr_valid), 0);

        // Backpressure: four accepts fill the credit, then one pop frees one
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, AW'(i), 1'b0, 1'b0);
            check("t2_stall_lo", 32'(bus.pc_stall), 0);
            check("t2_rom_en", 32'(bus.rom_en), 1);
            check("t2_rom_addr", 32'(bus.rom_addr), i);
        end
        repeat (2) begin
            cyc(1'b1, AW'(4), 1'b0, 1'b0);
            check("t2_stall_hi", 32'(bus.pc_stall), 1);
            check("t2_no_accept", 32'(bus.rom_en), 0);
        end
        cyc(1'b1, AW'(4), 1'b1, 1'b0);
        check("t2_pop_stall", 32'(bus.pc_stall), 1);
        check("t2_head", 32'(bus.instr_addr), 0);
        cyc(1'b1, AW'(4), 1'b0, 1'b0);
        check("t2_accept4_stall", 32'(bus.pc_stall), 0);
        check("t2_accept4_en", 32'(bus.rom_en), 1);
        check("t2_accept4_addr", 32'(bus.rom_addr), 4);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t2_inflight_stall", 32'(bus.pc_stall), 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t2_full_stall", 32'(bus.pc_stall), 1);

        // Full buffer, pop without accept, then drain
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t4_full_pop_stall", 32'(bus.pc_stall), 1);
        check("t4_full_head", 32'(bus.instr_addr), 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t4_after_pop_stall", 32'(bus.pc_stall), 0);
        check("t4_after_pop_head", 32'(bus.instr_addr), 2);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t4_drained", 32'(bus.instr_valid), 0);

        // Pointer wrap with ten back-to-back push/pop pairs
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, AW'(30 + i), 1'b1, 1'b0);
            if (i >= 2) check("t4_wrap_addr", 32'(bus.instr_addr), 28 + i);
        end
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        check("t4_wrap_empty", 32'(bus.instr_valid), 0);

        // Flush with 5,6 buffered and 7 in flight
        cyc(1'b1, AW'(5), 1'b0, 1'b0);
        cyc(1'b1, AW'(6), 1'b0, 1'b0);
        cyc(1'b1, AW'(7), 1'b0, 1'b0);
        check("t3_accept7", 32'(bus.rom_en), 1);
        cyc(1'b1, AW'(8), 1'b0, 1'b1);
        check("t3_flush_stall", 32'(bus.pc_stall), 1);
        check("t3_flush_no_accept", 32'(bus.rom_en), 0);
        check("t3_pre_flush_head", 32'(bus.instr_addr), 5);
        cyc(1'b1, AW'(20), 1'b1, 1'b0);
        check("t3_flushed_valid", 32'(bus.instr_valid), 0);
        check("t3_flushed_stall", 32'(bus.pc_stall), 0);
        check("t3_accept20", 32'(bus.rom_en), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t3_no_stale7", 32'(bus.instr_valid), 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t3_valid20", 32'(bus.instr_valid), 1);
        check("t3_addr20", 32'(bus.instr_addr), 20);
        check("t3_data20", 32'(bus.instr), 32'h114);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t3_empty", 32'(bus.instr_valid), 0);

        // Reset with three entries buffered
        cyc(1'b1, AW'(10), 1'b0, 1'b0);
        cyc(1'b1, AW'(11), 1'b0, 1'b0);
        cyc(1'b1, AW'(12), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t5_pre_valid", 32'(bus.instr_valid), 1);
        check("t5_pre_head", 32'(bus.instr_addr), 10);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.pc_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", 32'(bus.instr_valid), 0);
        check("t5_rst_stall", 32'(bus.pc_stall), 0);
        check("t5_rst_rom_en", 32'(bus.rom_en), 0);
        cyc(1'b1, AW'(0), 1'b1, 1'b0);
        check("t5_accept0", 32'(bus.rom_en), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t5_latency", 32'(bus.instr_valid), 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t5_valid0", 32'(bus.instr_valid), 1);
        check("t5_addr0", 32'(bus.instr_addr), 0);
        check("t5_data0", 32'(bus.instr), 32'h100);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t5_empty", 32'(bus.instr_valid), 0);

        // Randomized valid/ready with rare flushes; PC holds its address under stall
        next_addr = AW'(40);
        for (int i = 0; i < 1000; i++) begin
            logic v, rdy, fl;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 49) == 0);
            cyc(v, next_addr, rdy, fl);
            if (v && !fl && !bus.pc_stall) next_addr = next_addr + AW'(1);
        end
        repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
        check("rand_drain_queue", exp_q.size(), 0);
        check("rand_drain_valid", 32'(bus.instr_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
